// File: rtl/axi_mem_model_pkg.sv
// Shared types and helpers for the on-chip AXI memory model.
package axi_mem_model_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 16;

   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/axi_mem_model_if.sv
// Memory-side command/data bus between the AXI slave BFM (master) and the memory model (slave).
interface axi_mem_model_if #(
   parameter int DATA_WIDTH = 512,
   parameter int ADDR_WIDTH = 64,
   parameter int MASK_WIDTH = DATA_WIDTH / 8
);
   logic                  mem_wr_cmd_rdy;
   logic [DATA_WIDTH-1:0] mem_wr_data;
   logic [MASK_WIDTH-1:0] mem_wr_datamask;
   logic [ADDR_WIDTH-1:0] mem_wr_addr;
   logic                  mem_rd_cmd_rdy;
   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_rd_addr;
   logic [DATA_WIDTH-1:0] mem_rd_data;
   logic                  mem_rd_data_vld;

   modport master (
      input  mem_wr_cmd_rdy, mem_rd_cmd_rdy, mem_rd_data, mem_rd_data_vld,
      output mem_wr_data, mem_wr_datamask, mem_wr_addr, mem_rd_en, mem_rd_addr
   );

   modport slave (
      output mem_wr_cmd_rdy, mem_rd_cmd_rdy, mem_rd_data, mem_rd_data_vld,
      input  mem_wr_data, mem_wr_datamask, mem_wr_addr, mem_rd_en, mem_rd_addr
   );
endinterface

// File: rtl/axi_mem_model_rd_pipe.sv
// Read-return pipeline: LAT cycles from load to out_vld, no back-pressure.
// Data registers only advance with a valid beat, so the output holds its last value.
module axi_mem_model_rd_pipe #(
   parameter int LAT = 4,
   parameter int W   = 512
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_vld,
   input  logic [W-1:0] in_data,
   output logic         out_vld,
   output logic [W-1:0] out_data
);
   logic [LAT-1:0] vld;
   logic [W-1:0]   data [LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         for (int i = 0; i < LAT; i++) data[i] <= '0;
      end else begin
         vld[0] <= in_vld;
         if (in_vld) data[0] <= in_data;
         for (int i = 1; i < LAT; i++) begin
            vld[i] <= vld[i-1];
            if (vld[i-1]) data[i] <= data[i-1];
         end
      end
   end

   assign out_vld  = vld[LAT-1];
   assign out_data = data[LAT-1];
endmodule

// File: rtl/axi_mem_model.sv
// Behavioural memory model: byte-masked writes, reads return after RD_LATENCY cycles, periodic cmd stalls.
// Optional sticky alias/unaligned address check under `AXI_MEM_MODEL_ADDR_CHK_EN.
module axi_mem_model
   import axi_mem_model_pkg::*;
#(
   parameter int DATA_WIDTH      = 512,
   parameter int ADDR_WIDTH      = 64,
   parameter int MASK_WIDTH      = DATA_WIDTH / 8,
   parameter int DEPTH_LOG2      = 10,
   parameter int RD_LATENCY      = 4,
   parameter int WR_STALL_PERIOD = 16,
   parameter int WR_STALL_CYCLES = 0,
   parameter int RD_STALL_PERIOD = 16,
   parameter int RD_STALL_CYCLES = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   axi_mem_model_if.slave mem,
   output logic           init_done,
   output logic           addr_err
);
   localparam int OFF_W  = clog2(MASK_WIDTH);
   localparam int DEPTH  = 1 << DEPTH_LOG2;
   localparam int IDX_HI = OFF_W + DEPTH_LOG2 - 1;
   localparam int WR_CW  = (WR_STALL_PERIOD > 1) ? clog2(WR_STALL_PERIOD) : 1;
   localparam int RD_CW  = (RD_STALL_PERIOD > 1) ? clog2(RD_STALL_PERIOD) : 1;

   if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_lat_chk
      $error("axi_mem_model: RD_LATENCY out of range");
   end

   state_t                state, state_nxt;
   logic [DEPTH_LOG2:0]   init_idx;
   logic                  init_we;
   logic [WR_CW-1:0]      wr_cnt, wr_cnt_nxt;
   logic [RD_CW-1:0]      rd_cnt, rd_cnt_nxt;
   logic                  wr_rdy, rd_rdy;
   logic                  wr_fire, rd_fire;
   logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] ram [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_INIT;
         init_idx <= '0;
      end else begin
         state <= state_nxt;
         if (init_we) init_idx <= init_idx + 1'b1;
      end
   end

   // init_idx runs one past the last word; that extra cycle is the INIT->RUN handover.
   always_comb begin
      state_nxt = state;
      init_we   = 1'b0;
      unique case (state)
         ST_INIT: begin
            if (init_idx[DEPTH_LOG2]) state_nxt = ST_RUN;
            else                      init_we   = 1'b1;
         end
         ST_RUN: state_nxt = ST_RUN;
      endcase
   end

   assign wr_cnt_nxt = (state != ST_RUN) ? '0 :
                       (wr_cnt == WR_CW'(WR_STALL_PERIOD - 1)) ? '0 : wr_cnt + 1'b1;
   assign rd_cnt_nxt = (state != ST_RUN) ? '0 :
                       (rd_cnt == RD_CW'(RD_STALL_PERIOD - 1)) ? '0 : rd_cnt + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         wr_rdy    <= 1'b0;
         rd_rdy    <= 1'b0;
         init_done <= 1'b0;
      end else begin
         wr_cnt    <= wr_cnt_nxt;
         rd_cnt    <= rd_cnt_nxt;
         wr_rdy    <= (state_nxt == ST_RUN) && (int'(wr_cnt_nxt) >= WR_STALL_CYCLES);
         rd_rdy    <= (state_nxt == ST_RUN) && (int'(rd_cnt_nxt) >= RD_STALL_CYCLES);
         init_done <= (state_nxt == ST_RUN);
      end
   end

   assign mem.mem_wr_cmd_rdy = wr_rdy;
   assign mem.mem_rd_cmd_rdy = rd_rdy;

   assign wr_idx  = mem.mem_wr_addr[IDX_HI:OFF_W];
   assign rd_idx  = mem.mem_rd_addr[IDX_HI:OFF_W];
   assign wr_fire = wr_rdy && (|mem.mem_wr_datamask);
   assign rd_fire = rd_rdy && mem.mem_rd_en;

   always_ff @(posedge clk) begin
      if (init_we) begin
         ram[init_idx[DEPTH_LOG2-1:0]] <= '0;
      end else if (wr_fire) begin
         for (int i = 0; i < MASK_WIDTH; i++)
            if (mem.mem_wr_datamask[i]) ram[wr_idx][i*8 +: 8] <= mem.mem_wr_data[i*8 +: 8];
      end
   end

   // Write-first: a same-cycle write to the read index is visible to the read.
   always_comb begin
      rd_word = ram[rd_idx];
      if (wr_fire && (wr_idx == rd_idx)) begin
         for (int i = 0; i < MASK_WIDTH; i++)
            if (mem.mem_wr_datamask[i]) rd_word[i*8 +: 8] = mem.mem_wr_data[i*8 +: 8];
      end
   end

   axi_mem_model_rd_pipe #(
      .LAT (RD_LATENCY),
      .W   (DATA_WIDTH)
   ) u_rd_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (rd_fire),
      .in_data  (rd_word),
      .out_vld  (mem.mem_rd_data_vld),
      .out_data (mem.mem_rd_data)
   );

`ifdef AXI_MEM_MODEL_ADDR_CHK_EN
   logic wr_bad, rd_bad;

   assign wr_bad = wr_fire && ((|mem.mem_wr_addr[ADDR_WIDTH-1:IDX_HI+1]) ||
                               (|mem.mem_wr_addr[OFF_W-1:0]));
   assign rd_bad = rd_fire && ((|mem.mem_rd_addr[ADDR_WIDTH-1:IDX_HI+1]) ||
                               (|mem.mem_rd_addr[OFF_W-1:0]));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_err <= 1'b0;
      end else begin
         if (wr_bad || rd_bad) addr_err <= 1'b1;
`ifndef SYNTHESIS
         if (wr_bad) $error("axi_mem_model: bad write address 0x%h", mem.mem_wr_addr);
         if (rd_bad) $error("axi_mem_model: bad read address 0x%h", mem.mem_rd_addr);
`endif
      end
   end
`else
   logic unused_addr_bits;
   assign unused_addr_bits = ^{mem.mem_wr_addr[ADDR_WIDTH-1:IDX_HI+1], mem.mem_wr_addr[OFF_W-1:0],
                               mem.mem_rd_addr[ADDR_WIDTH-1:IDX_HI+1], mem.mem_rd_addr[OFF_W-1:0]};
   assign addr_err = 1'b0;
`endif
endmodule

// File: tb/tb_axi_mem_model.sv
// Randomized bench for axi_mem_model against a word-array reference model.
module tb_axi_mem_model;
   localparam int DW  = 512;
   localparam int AW  = 64;
   localparam int MW  = 64;
   localparam int DL  = 4;
   localparam int LAT = 4;

   logic clk, rst_n, init_done, addr_err;
   int   vectors = 0, miscompares = 0, edges = 0, run_edge = 0;
   logic [DW-1:0] model_mem [16];

   axi_mem_model_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

   axi_mem_model #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASK_WIDTH(MW), .DEPTH_LOG2(DL), .RD_LATENCY(LAT),
      .WR_STALL_PERIOD(8), .WR_STALL_CYCLES(3), .RD_STALL_PERIOD(16), .RD_STALL_CYCLES(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mem(bus), .init_done(init_done), .addr_err(addr_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) edges++;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int j = 0; j < DW / 32; j++) w[j*32 +: 32] = $urandom;
      return w;
   endfunction

   // Model: the word index is addr / 64 modulo 16; each enabled byte lane replaces the old byte.
   function automatic void model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                       input logic [MW-1:0] mask);
      int idx = int'((addr / 64) % 16);
      for (int b = 0; b < MW; b++)
         if (mask[b]) model_mem[idx][b*8 +: 8] = data[b*8 +: 8];
   endfunction

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] addr);
      return model_mem[int'((addr / 64) % 16)];
   endfunction

   task automatic release_and_wait(output int n);
      @(posedge clk); #1;
      rst_n = 1'b1;
      n = 0;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         if (n == 8) begin
            vectors++;
            if ({bus.mem_wr_cmd_rdy, bus.mem_rd_cmd_rdy} !== 2'b00) begin
               miscompares++;
               $display("FAIL rdy_during_init: got %b want 00", {bus.mem_wr_cmd_rdy, bus.mem_rd_cmd_rdy});
            end
         end
         if (init_done === 1'b1) break;
      end
      run_edge = edges;
      for (int i = 0; i < 16; i++) model_mem[i] = '0;
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [MW-1:0] mask);
      int n = 0;
      while (bus.mem_wr_cmd_rdy !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
      if (n >= 64) begin
         vectors++; miscompares++;
         $display("FAIL wr_rdy_timeout: got 0 want 1 within 64 cycles");
         return;
      end
      bus.mem_wr_addr = addr; bus.mem_wr_data = data; bus.mem_wr_datamask = mask;
      @(posedge clk);
      model_write(addr, data, mask);
      #1 bus.mem_wr_datamask = '0;
   endtask

   task automatic do_read(input logic [AW-1:0] addr, output logic [DW-1:0] data, output int lat);
      int n = 0;
      while (bus.mem_rd_cmd_rdy !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
      bus.mem_rd_en = 1'b1; bus.mem_rd_addr = addr;
      @(posedge clk); #1;
      bus.mem_rd_en = 1'b0;
      lat = 1;
      while (bus.mem_rd_data_vld !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
      data = bus.mem_rd_data;
      if (bus.mem_rd_data_vld !== 1'b1) lat = -1;
   endtask

   task automatic test_reset();
      int n, lat;
      logic [DW-1:0] d;
      rst_n = 1'b1;
      bus.mem_rd_en = 1'b0; bus.mem_wr_datamask = '0;
      bus.mem_wr_addr = '0; bus.mem_wr_data = '0; bus.mem_rd_addr = '0;
      #2 rst_n = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      vectors++;
      if ({bus.mem_wr_cmd_rdy, bus.mem_rd_cmd_rdy, bus.mem_rd_data_vld, init_done, addr_err} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got %b want 00000",
                  {bus.mem_wr_cmd_rdy, bus.mem_rd_cmd_rdy, bus.mem_rd_data_vld, init_done, addr_err});
      end
      vectors++;
      if (bus.mem_rd_data !== '0) begin
         miscompares++; $display("FAIL reset_rd_data: got %h want 0", bus.mem_rd_data);
      end
      release_and_wait(n);
      vectors++;
      if (n !== 17) begin miscompares++; $display("FAIL init_done_cycles: got %0d want 17", n); end
      vectors++;
      if ({bus.mem_wr_cmd_rdy, bus.mem_rd_cmd_rdy} !== 2'b01) begin
         miscompares++;
         $display("FAIL rdy_at_run_entry: got %b want 01", {bus.mem_wr_cmd_rdy, bus.mem_rd_cmd_rdy});
      end
      do_read(64'h0, d, lat);
      vectors++;
      if (lat !== LAT || d !== '0) begin
         miscompares++; $display("FAIL first_read: got lat %0d data %h want lat 4 data 0", lat, d);
      end
   endtask

   task automatic test_addr_chk();
      int lat;
      logic [DW-1:0] d;
      logic exp_err;
`ifdef AXI_MEM_MODEL_ADDR_CHK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      vectors++;
      if (addr_err !== 1'b0) begin miscompares++; $display("FAIL addr_err_clean: got %b want 0", addr_err); end
      bus.mem_rd_en = 1'b1; bus.mem_rd_addr = 64'h41;
      @(posedge clk); #1;
      bus.mem_rd_en = 1'b0;
      vectors++;
      if (addr_err !== exp_err) begin miscompares++; $display("FAIL addr_err_set: got %b want %b", addr_err, exp_err); end
      repeat (6) begin @(posedge clk); #1; end
      vectors++;
      if (addr_err !== exp_err) begin miscompares++; $display("FAIL addr_err_held: got %b want %b", addr_err, exp_err); end
      d = '0; lat = 0;
   endtask

   task automatic test_write_read();
      int lat;
      logic [DW-1:0] d, exp;
      exp = {MW{8'hA5}};
      do_write(64'h40, exp, {MW{1'b1}});
      do_read(64'h40, d, lat);
      vectors++;
      if (lat !== LAT || d !== exp) begin
         miscompares++; $display("FAIL read_0x40: got lat %0d data %h want lat 4 data %h", lat, d, exp);
      end
      do_read(64'h40 + 16 * 64, d, lat);
      vectors++;
      if (lat !== LAT || d !== exp) begin
         miscompares++; $display("FAIL read_alias: got lat %0d data %h want lat 4 data %h", lat, d, exp);
      end
      repeat (3) begin @(posedge clk); #1; end
      vectors++;
      if (bus.mem_rd_data_vld !== 1'b0 || bus.mem_rd_data !== exp) begin
         miscompares++; $display("FAIL rd_data_hold: got vld %b data %h want vld 0 data %h",
                                 bus.mem_rd_data_vld, bus.mem_rd_data, exp);
      end
   endtask

   task automatic test_masked();
      int lat;
      logic [DW-1:0] d, exp;
      exp = '0; exp[7:0] = 8'hFF;
      do_write(64'h80, {MW{8'hFF}}, 64'h1);
      do_read(64'h80, d, lat);
      vectors++;
      if (lat !== LAT || d !== exp) begin
         miscompares++; $display("FAIL masked_byte0: got %h want %h", d, exp);
      end
   endtask

   task automatic test_write_first();
      logic [DW-1:0] wd [2];
      logic [MW-1:0] wm [2];
      logic [AW-1:0] wa [2];
      logic [DW-1:0] exp;
      int lat;
      do_write(64'h100, rand_word(), {MW{1'b1}});
      wa[0] = 64'hC0;  wd[0] = {MW{8'h11}}; wm[0] = {MW{1'b1}};
      wa[1] = 64'h100; wd[1] = rand_word();  wm[1] = {$urandom, $urandom};
      for (int t = 0; t < 2; t++) begin
         while (bus.mem_wr_cmd_rdy !== 1'b1) begin @(posedge clk); #1; end
         bus.mem_wr_addr = wa[t]; bus.mem_wr_data = wd[t]; bus.mem_wr_datamask = wm[t];
         bus.mem_rd_addr = wa[t]; bus.mem_rd_en = 1'b1;
         @(posedge clk);
         model_write(wa[t], wd[t], wm[t]);
         exp = model_read(wa[t]);
         #1 bus.mem_wr_datamask = '0; bus.mem_rd_en = 1'b0;
         lat = 1;
         while (bus.mem_rd_data_vld !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
         vectors++;
         if (lat !== LAT || bus.mem_rd_data !== exp) begin
            miscompares++;
            $display("FAIL write_first_%0d: got lat %0d data %h want lat 4 data %h", t, lat, bus.mem_rd_data, exp);
         end
      end
   endtask

   task automatic test_wr_stall();
      int lows = 0, k;
      logic exp;
      for (int c = 0; c < 32; c++) begin
         @(posedge clk); #1;
         k   = edges - run_edge;
         exp = ((k % 8) >= 3);
         if (bus.mem_wr_cmd_rdy === 1'b0) lows++;
         vectors++;
         if (bus.mem_wr_cmd_rdy !== exp || bus.mem_rd_cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_stall_k%0d: got wr %b rd %b want wr %b rd 1", k, bus.mem_wr_cmd_rdy,
                     bus.mem_rd_cmd_rdy, exp);
         end
      end
      vectors++;
      if (lows !== 12) begin miscompares++; $display("FAIL wr_stall_lows: got %0d want 12 of 32", lows); end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] exp_q [$];
      logic [DW-1:0] got_q [$];
      int            cyc_q [$];
      for (int i = 0; i < 8; i++) do_write(AW'((8 + i) * 64), rand_word(), {MW{1'b1}});
      for (int i = 0; i < 8; i++) exp_q.push_back(model_read(AW'((8 + i) * 64)));
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               bus.mem_rd_en = 1'b1; bus.mem_rd_addr = AW'((8 + i) * 64);
               @(posedge clk); #1;
            end
            bus.mem_rd_en = 1'b0;
         end
         begin
            for (int c = 1; c <= 16; c++) begin
               @(posedge clk); #1;
               if (bus.mem_rd_data_vld === 1'b1) begin
                  cyc_q.push_back(c); got_q.push_back(bus.mem_rd_data);
               end
            end
         end
      join
      vectors++;
      if (cyc_q.size() !== 8) begin
         miscompares++; $display("FAIL b2b_count: got %0d pulses want 8", cyc_q.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            vectors++;
            if (cyc_q[i] !== i + LAT || got_q[i] !== exp_q[i]) begin
               miscompares++;
               $display("FAIL b2b_beat%0d: got cyc %0d data %h want cyc %0d data %h",
                        i, cyc_q[i], got_q[i], i + LAT, exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [AW-1:0] a;
      logic [DW-1:0] d, exp;
      int lat;
      for (int it = 0; it < 40; it++) begin
         a = AW'($urandom_range(0, 15) * 64 + ($urandom_range(0, 3) << 10));
         if ($urandom_range(0, 1) == 1) begin
            do_write(a, rand_word(), {$urandom, $urandom});
         end else begin
            exp = model_read(a);
            do_read(a, d, lat);
            vectors++;
            if (lat !== LAT || d !== exp) begin
               miscompares++;
               $display("FAIL rand_rd_%0d addr %h: got lat %0d data %h want lat 4 data %h", it, a, lat, d, exp);
            end
         end
      end
   endtask

   task automatic test_reset_midop();
      int n, lat;
      logic [DW-1:0] d;
      do_write(64'h40, {MW{8'h5A}}, {MW{1'b1}});
      bus.mem_rd_en = 1'b1; bus.mem_rd_addr = 64'h40;
      @(posedge clk); #1;
      bus.mem_rd_en = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({bus.mem_wr_cmd_rdy, bus.mem_rd_cmd_rdy, bus.mem_rd_data_vld, init_done, addr_err} !== 5'b0
          || bus.mem_rd_data !== '0) begin
         miscompares++;
         $display("FAIL midop_reset: got flags %b data %h want 00000 and 0",
                  {bus.mem_wr_cmd_rdy, bus.mem_rd_cmd_rdy, bus.mem_rd_data_vld, init_done, addr_err}, bus.mem_rd_data);
      end
      release_and_wait(n);
      vectors++;
      if (n !== 17) begin miscompares++; $display("FAIL reinit_cycles: got %0d want 17", n); end
      do_read(64'h40, d, lat);
      vectors++;
      if (lat !== LAT || d !== '0) begin
         miscompares++; $display("FAIL reinit_clear: got lat %0d data %h want lat 4 data 0", lat, d);
      end
   endtask

   initial begin
      test_reset();
      test_addr_chk();
      test_write_read();
      test_masked();
      test_write_first();
      test_wr_stall();
      test_back_to_back();
      test_random();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
